// File: rtl/inv_factorial_seq_pkg.sv
// Shared definitions for the inverse-factorial block.
//   state_t / IDLE, CALC, DONE : controller state encoding
//   MAX_N                      : largest n whose factorial fits in 32 bits
//   FACT_TABLE                 : 0! .. 12!, used for reference and assertions
package inv_fact_pkg;

    localparam int MAX_N = 12;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t DONE = 2'd2;

    localparam logic [31:0] FACT_TABLE [0:12] = '{
        32'd1,        32'd1,        32'd2,         32'd6,
        32'd24,       32'd120,      32'd720,       32'd5040,
        32'd40320,    32'd362880,   32'd3628800,   32'd39916800,
        32'd479001600
    };

endpackage

// File: rtl/inv_factorial_seq_if.sv
// Handshake bundle for inv_factorial_seq.
//   in_valid/in_ready/in_value          : request side
//   out_valid/out_ready/out_n/out_fact/
//   out_exact                           : result side
// slave is the block's view, master is the source/consumer view.
interface inv_factorial_seq_if #(
    parameter int WIDTH = 32,
    parameter int NW    = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_value;
    logic             out_valid;
    logic             out_ready;
    logic [NW-1:0]    out_n;
    logic [WIDTH-1:0] out_fact;
    logic             out_exact;

    modport master (
        output in_valid, in_value, out_ready,
        input  in_ready, out_valid, out_n, out_fact, out_exact
    );

    modport slave (
        input  in_valid, in_value, out_ready,
        output in_ready, out_valid, out_n, out_fact, out_exact
    );
endinterface

// File: rtl/inv_factorial_seq_fact_step.sv
// One iteration of the inverse-factorial search (combinational).
//   acc      : current k!
//   k        : current candidate n
//   value    : captured input value
//   next_acc : (k+1)!, low WIDTH bits, only meaningful when stop is low
//   stop     : (k+1)! exceeds value, or k has reached MAX_N
module fact_step
    import inv_fact_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NW    = 4,
    parameter int MAX_N = inv_fact_pkg::MAX_N
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [NW-1:0]    k,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] next_acc,
    output logic             stop
);
    // The product is kept at full width so 13! (or any product past the
    // WIDTH range) compares correctly instead of wrapping.
    logic [WIDTH+NW:0] acc_w;
    logic [WIDTH+NW:0] kp1_w;
    logic [WIDTH+NW:0] val_w;
    logic [WIDTH+NW:0] prod;
    logic [NW:0]       kp1;

    assign kp1   = {1'b0, k} + {{NW{1'b0}}, 1'b1};
    assign acc_w = {{(NW+1){1'b0}}, acc};
    assign kp1_w = {{WIDTH{1'b0}}, kp1};
    assign val_w = {{(NW+1){1'b0}}, value};
    assign prod  = acc_w * kp1_w;

    assign next_acc = prod[WIDTH-1:0];
    assign stop     = (prod[WIDTH+NW:WIDTH] != '0) || (prod > val_w)
                      || (k == NW'(MAX_N));
endmodule

// File: rtl/inv_factorial_seq.sv
// Sequential inverse factorial: for an accepted value, reports the largest n
// with n! <= value, that n!, and whether value is exactly n!.
// One multiply-compare per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : inv_factorial_seq_if.slave (request and result handshakes)
module inv_factorial_seq
    import inv_fact_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NW    = 4,
    parameter int MAX_N = inv_fact_pkg::MAX_N
) (
    input  logic                  clk,
    input  logic                  rst_n,
    inv_factorial_seq_if.slave    bus
);
    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [NW-1:0]    k;
    logic [WIDTH-1:0] value_q;
    logic [NW-1:0]    out_n_q;
    logic [WIDTH-1:0] out_fact_q;
    logic             out_exact_q;

    logic [WIDTH-1:0] next_acc;
    logic             stop;

    fact_step #(
        .WIDTH (WIDTH),
        .NW    (NW),
        .MAX_N (MAX_N)
    ) u_step (
        .acc      (acc),
        .k        (k),
        .value    (value_q),
        .next_acc (next_acc),
        .stop     (stop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= WIDTH'(1);
            k           <= NW'(1);
            value_q     <= '0;
            out_n_q     <= '0;
            out_fact_q  <= '0;
            out_exact_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        value_q <= bus.in_value;
                        acc     <= WIDTH'(1);
                        k       <= NW'(1);
                        // Zero has no n with n! <= 0; report n=0, fact=1.
                        if (bus.in_value == '0) begin
                            out_n_q     <= '0;
                            out_fact_q  <= WIDTH'(1);
                            out_exact_q <= 1'b0;
                            state       <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (stop) begin
                        out_n_q     <= k;
                        out_fact_q  <= acc;
                        out_exact_q <= (acc == value_q);
                        state       <= DONE;
                    end else begin
                        acc <= next_acc;
                        k   <= k + NW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_n     = out_n_q;
    assign bus.out_fact  = out_fact_q;
    assign bus.out_exact = out_exact_q;

    // A reported result must always be a true factorial.
    always @(posedge clk) begin
        if (rst_n && state == DONE && out_n_q <= NW'(MAX_N)) begin
            assert (out_fact_q == WIDTH'(FACT_TABLE[out_n_q]));
        end
    end
endmodule

// File: tb/tb_inv_factorial_seq.sv
module tb_inv_factorial_seq;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    inv_factorial_seq_if #(.WIDTH(32), .NW(4)) bus ();

    inv_factorial_seq #(.WIDTH(32), .NW(4), .MAX_N(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Reference: largest n with n! <= v, by straightforward arithmetic.
    function automatic void model(input logic [31:0] v, output int n,
                                  output longint f, output bit ex);
        longint lv;
        lv = longint'(v);
        if (v == 32'd0) begin
            n = 0; f = 1; ex = 1'b0;
            return;
        end
        n = 1; f = 1;
        while (n < 12 && f * (n + 1) <= lv) begin
            n = n + 1;
            f = f * n;
        end
        ex = (f == lv);
    endfunction

    function automatic logic [31:0] fact_of(input int m);
        longint f;
        f = 1;
        for (int i = 1; i <= m; i++) f = f * i;
        return f[31:0];
    endfunction

    task automatic do_op(input logic [31:0] v, input int hold, input string tag);
        int     n, lat, guard, exp_lat;
        longint f;
        bit     ex;
        logic [3:0]  sn;
        logic [31:0] sf;
        logic        se;
        model(v, n, f, ex);
        exp_lat = (v == 32'd0) ? 1 : n + 1;

        bus.in_value = v;
        bus.in_valid = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            check({tag, "_accept_timeout"}, 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;             // accept edge
        bus.in_valid = 1'b0;
        bus.in_value = $urandom;        // must be ignored after accept
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_n"},       bus.out_n, n);
        check({tag, "_fact"},    bus.out_fact, f);
        check({tag, "_exact"},   bus.out_exact, ex);
        check({tag, "_inrdy_done"}, bus.in_ready, 0);

        sn = bus.out_n; sf = bus.out_fact; se = bus.out_exact;
        if (hold > 0) begin
            // Offer a competing input during the stall; it must not be taken.
            bus.in_valid = 1'b1;
            bus.in_value = 32'd720;
        end
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check({tag, "_stall"},
                  {bus.out_valid, bus.in_ready, bus.out_exact, bus.out_n, bus.out_fact},
                  {1'b1, 1'b0, se, sn, sf});
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check({tag, "_released"}, {bus.out_valid, bus.in_ready}, 2'b01);
    endtask

    initial begin
        logic [31:0] v;
        int          m, guard;
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_value  = '0;
        bus.out_ready = 1'b0;
        #3;
        check("reset_state",
              {bus.in_ready, bus.out_valid, bus.out_n, bus.out_fact, bus.out_exact},
              {1'b1, 1'b0, 4'd0, 32'd0, 1'b0});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(32'd24, 0, "v24");
        do_op(32'd25, 0, "v25");
        do_op(32'd119, 1, "v119");
        do_op(32'd120, 0, "v120");
        do_op(32'd0, 0, "v0");
        do_op(32'd1, 0, "v1");
        do_op(32'd479001600, 0, "v12f");
        do_op(32'hFFFFFFFF, 0, "vmax");
        do_op(32'd479001599, 0, "v12m1");
        do_op(32'd5040, 10, "bp");
        do_op(32'd720, 0, "after_bp");

        // Reset in the middle of a calculation.
        bus.in_value = 32'd3628800;
        bus.in_valid = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midcalc_reset",
              {bus.in_ready, bus.out_valid, bus.out_n, bus.out_fact, bus.out_exact},
              {1'b1, 1'b0, 4'd0, 32'd0, 1'b0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("discarded_result", {bus.out_valid, bus.in_ready}, 2'b01);
        do_op(32'd6, 0, "v6_post_reset");

        // Randomised values against the model.
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = $urandom_range(0, 200);
                2: begin
                    m = $urandom_range(0, 12);
                    v = fact_of(m) + 32'($urandom_range(0, 2)) - 32'd1;
                end
                default: v = 32'd479001600 + 32'($urandom_range(0, 4)) - 32'd2;
            endcase
            do_op(v, $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
